// File: rtl/mr_witness_check_if.sv
// Job bundle for the Miller-Rabin witness checker: operand capture handshake plus result strobe.
// The master drives p/x with a one-cycle x_valid pulse; the slave reports in_ready, res_valid and res_prime.
interface mr_witness_check_if #(
    parameter int BIT_LENGTH = 128
);
    logic [BIT_LENGTH-1:0] p_value;
    logic                  x_valid;
    logic [BIT_LENGTH-1:0] x_value;
    logic                  in_ready;
    logic                  res_valid;
    logic                  res_prime;

    modport master (
        output p_value, x_valid, x_value,
        input  in_ready, res_valid, res_prime
    );

    modport slave (
        input  p_value, x_valid, x_value,
        output in_ready, res_valid, res_prime
    );
endinterface

// File: rtl/mr_witness_check.sv
// Miller-Rabin witness check on x = a^d mod p; latency (r+1)+passes*(SQ+1)+2 cycles, SQ = BIT_LENGTH or 1.
// in_ready only in IDLE, x_valid while busy is dropped; MR_FAST_SQUARE_EN selects a one-cycle combinational square.
module mr_witness_check #(
    parameter int BIT_LENGTH = 128
) (
    input logic               aclk,
    input logic               areset,
    mr_witness_check_if.slave job
);
    localparam int CNT_W = $clog2(BIT_LENGTH) + 1;

    typedef enum logic [2:0] {IDLE, TZ, CHECK, SQ, DONE} state_t;

    state_t                state_q, state_d;
    logic [BIT_LENGTH-1:0] p_q, x_q, d_q;
    logic [CNT_W-1:0]      r_q, i_q;
    logic                  res_prime_q;

    logic                  trivial_p;
    logic                  check_hit;
    logic                  check_last;
    logic                  sq_last;
    logic [BIT_LENGTH-1:0] sq_result;

    assign trivial_p  = (job.p_value < BIT_LENGTH'(3)) || !job.p_value[0];
    assign check_hit  = (x_q == BIT_LENGTH'(1)) || (x_q == p_q - BIT_LENGTH'(1));
    assign check_last = (i_q == r_q - CNT_W'(1));

`ifdef MR_FAST_SQUARE_EN
    logic [2*BIT_LENGTH-1:0] sq_full;

    always_comb begin
        sq_full   = {{BIT_LENGTH{1'b0}}, x_q} * {{BIT_LENGTH{1'b0}}, x_q};
        sq_result = BIT_LENGTH'(sq_full % {{BIT_LENGTH{1'b0}}, p_q});
        sq_last   = 1'b1;
    end
`else
    localparam int K_W   = (BIT_LENGTH > 1) ? $clog2(BIT_LENGTH) : 1;
    localparam int ACC_W = BIT_LENGTH + 2;

    logic [K_W-1:0]   k_q;
    logic [ACC_W-1:0] acc_q, p_ext, acc_sum, acc_red1, acc_red2;

    // acc < p on entry, so 2*acc + x < 3p: two conditional subtractions always bring it back below p
    always_comb begin
        p_ext     = {2'b00, p_q};
        acc_sum   = {acc_q[ACC_W-2:0], 1'b0} + (x_q[k_q] ? {2'b00, x_q} : '0);
        acc_red1  = (acc_sum >= p_ext) ? acc_sum - p_ext : acc_sum;
        acc_red2  = (acc_red1 >= p_ext) ? acc_red1 - p_ext : acc_red1;
        sq_result = acc_red2[BIT_LENGTH-1:0];
        sq_last   = (k_q == '0);
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job.x_valid) state_d = trivial_p ? DONE : TZ;
            TZ:      if (d_q[0]) state_d = CHECK;
            CHECK:   state_d = (check_hit || check_last) ? DONE : SQ;
            SQ:      if (sq_last) state_d = CHECK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        job.in_ready  = (state_q == IDLE);
        job.res_valid = (state_q == DONE);
    end

    assign job.res_prime = res_prime_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            p_q         <= '0;
            x_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            i_q         <= '0;
            res_prime_q <= 1'b0;
`ifndef MR_FAST_SQUARE_EN
            acc_q       <= '0;
            k_q         <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (job.x_valid) begin
                    p_q <= job.p_value;
                    x_q <= job.x_value;
                    d_q <= job.p_value - BIT_LENGTH'(1);
                    r_q <= '0;
                    i_q <= '0;
                    if (trivial_p) res_prime_q <= (job.p_value == BIT_LENGTH'(2));
                end
                TZ: if (!d_q[0]) begin
                    d_q <= d_q >> 1;
                    r_q <= r_q + CNT_W'(1);
                end
                CHECK: begin
                    if (check_hit)       res_prime_q <= 1'b1;
                    else if (check_last) res_prime_q <= 1'b0;
`ifndef MR_FAST_SQUARE_EN
                    else begin
                        acc_q <= '0;
                        k_q   <= K_W'(BIT_LENGTH - 1);
                    end
`endif
                end
                SQ: begin
`ifndef MR_FAST_SQUARE_EN
                    acc_q <= acc_red2;
                    k_q   <= k_q - K_W'(1);
`endif
                    if (sq_last) begin
                        x_q <= sq_result;
                        i_q <= i_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mr_witness_check.sv
// Directed and random jobs for mr_witness_check, checked against a plain-arithmetic witness model.
module tb_mr_witness_check;
    localparam int BL    = 128;
    localparam int LIMIT = 20000;
`ifdef MR_FAST_SQUARE_EN
    localparam int SQ_CYC = 1;
`else
    localparam int SQ_CYC = BL;
`endif

    logic aclk = 1'b0;
    logic areset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 aclk = ~aclk;

    mr_witness_check_if #(.BIT_LENGTH(BL)) job ();
    mr_witness_check #(.BIT_LENGTH(BL)) dut (.aclk(aclk), .areset(areset), .job(job));

    task automatic check(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Witness verdict straight from the number theory: factor p-1 = d*2^r, then test x, x^2, ... x^(2^(r-1)).
    function automatic logic mr_model(input logic [BL-1:0] p, input logic [BL-1:0] x);
        logic [BL-1:0]   d, y;
        logic [2*BL-1:0] y2;
        int              r;
        if (p < 3 || p[0] == 1'b0) return (p == 2);
        d = p - 1;
        r = 0;
        while (d[0] == 1'b0) begin
            d = d >> 1;
            r++;
        end
        y = x;
        for (int j = 0; j < r; j++) begin
            if (y == 1 || y == p - 1) return 1'b1;
            y2 = ({{BL{1'b0}}, y} * {{BL{1'b0}}, y}) % {{BL{1'b0}}, p};
            y  = y2[BL-1:0];
        end
        return 1'b0;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where res_valid was seen.
    task automatic run_job(input logic [BL-1:0] p, input logic [BL-1:0] x, input int glitch_at,
                           output int lat, output logic prime, output logic timeout);
        job.p_value = p;
        job.x_value = x;
        job.x_valid = 1'b1;
        @(posedge aclk);
        #1 job.x_valid = 1'b0;
        lat     = 0;
        prime   = 1'b0;
        timeout = 1'b1;
        for (int n = 1; n <= LIMIT; n++) begin
            @(negedge aclk);
            if (job.res_valid) begin
                lat     = n;
                prime   = job.res_prime;
                timeout = 1'b0;
                break;
            end
            if (n == glitch_at) begin
                job.x_valid = 1'b1;
                job.p_value = ~p;
                job.x_value = ~x;
            end else if (n == glitch_at + 1) begin
                job.x_valid = 1'b0;
                job.p_value = p;
                job.x_value = x;
            end
        end
    endtask

    task automatic do_job(input string tag, input logic [BL-1:0] p, input logic [BL-1:0] x,
                          input int exp_lat, input logic exp_prime, input int glitch_at);
        int   lat;
        logic prime, timeout;
        check({tag, " in_ready"}, BL'(job.in_ready), BL'(1));
        run_job(p, x, glitch_at, lat, prime, timeout);
        check({tag, " timeout"}, BL'(timeout), BL'(0));
        if (exp_lat >= 0) check({tag, " latency"}, BL'(lat), BL'(exp_lat));
        check({tag, " res_prime"}, BL'(prime), BL'(exp_prime));
        @(negedge aclk);
        check({tag, " res_valid single"}, BL'(job.res_valid), BL'(0));
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BL-1:0] p, x, xr;
        int            cnt;

        areset      = 1'b1;
        job.x_valid = 1'b0;
        job.p_value = '0;
        job.x_value = '0;
        #12;
        check("reset in_ready", BL'(job.in_ready), BL'(1));
        check("reset res_valid", BL'(job.res_valid), BL'(0));
        check("reset res_prime", BL'(job.res_prime), BL'(0));

        // accept lands on the first edge after release
        @(negedge aclk);
        areset = 1'b0;
        do_job("p13x8", BL'(13), BL'(8), 6 + SQ_CYC, 1'b1, -1);

        do_job("p221x47", BL'(221), BL'(47), 6 + SQ_CYC, 1'b1, -1);
        do_job("p221x188", BL'(221), BL'(188), 6 + SQ_CYC, 1'b0, -1);
        do_job("p13x1", BL'(13), BL'(1), 5, 1'b1, -1);
        do_job("p13x12", BL'(13), BL'(12), 5, 1'b1, -1);
        do_job("p2", BL'(2), BL'(0), 1, 1'b1, -1);
        do_job("p14", BL'(14), BL'(3), 1, 1'b0, -1);
        do_job("p1", BL'(1), BL'(0), 1, 1'b0, -1);

        // second pulse with different operands lands in SQ
        do_job("glitch", BL'(13), BL'(8), 6 + SQ_CYC, 1'b1, 5);
        cnt = 0;
        repeat (20) begin
            @(negedge aclk);
            if (job.res_valid) cnt++;
        end
        check("glitch extra res_valid", BL'(cnt), BL'(0));
        check("res_prime held", BL'(job.res_prime), BL'(1));

        // reset in the middle of the square pass
        job.p_value = BL'(13);
        job.x_value = BL'(8);
        job.x_valid = 1'b1;
        @(posedge aclk);
        #1 job.x_valid = 1'b0;
        repeat (5) @(negedge aclk);
        areset = 1'b1;
        #1;
        check("midreset in_ready", BL'(job.in_ready), BL'(1));
        check("midreset res_valid", BL'(job.res_valid), BL'(0));
        check("midreset res_prime", BL'(job.res_prime), BL'(0));
        @(negedge aclk);
        areset = 1'b0;
        cnt = 0;
        repeat (200) begin
            @(negedge aclk);
            if (job.res_valid) cnt++;
        end
        check("aborted job res_valid", BL'(cnt), BL'(0));
        do_job("after reset p13x8", BL'(13), BL'(8), 6 + SQ_CYC, 1'b1, -1);

        for (int t = 0; t < 24; t++) begin
            if (t < 12) begin
                p = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                p = BL'($urandom_range(255, 3));
            end
            p[0] = 1'b1;
            if (p < 3) p = BL'(3);
            xr = {$urandom, $urandom, $urandom, $urandom};
            x  = xr % p;
            do_job($sformatf("rand%0d", t), p, x, -1, mr_model(p, x), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
